// File: rtl/rf_pkg.sv
// Shared constants, types and the reset-contents helper for the multi-port register file.
package rf_pkg;
    localparam int WIDTH_DEF = 64;
    localparam int NREGS_DEF = 32;
    localparam int ZR_DEF    = 31;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [WIDTH_DEF-1:0]         reg_data_t;

    // Index-valued reset pattern lets software spot a register that was never written.
    function automatic reg_data_t init_val(input int unsigned i);
        return reg_data_t'(i);
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback; a new producer wins over a clear.
// Latency: one edge from set/clear to busy; no backpressure.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int ZR    = 31,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bs_en,
    input  logic [AW-1:0] bs_addr,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    output logic [NREGS-1:0] busy
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == ZR) begin
                    busy[i] <= 1'b0;
                end else if (bs_en && bs_addr == AW'(i)) begin
                    busy[i] <= 1'b1;
                end else if ((we0 && wa0 == AW'(i)) || (we1 && wa1 == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two prioritised write ports, optional bypass.
// Latency: reads zero-cycle, writes one edge; no backpressure.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZR       = ZR_DEF,
    parameter int INIT_IDX = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [WIDTH-1:0]     wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [WIDTH-1:0]     wd1,
    input  logic                 bs_en,
    input  logic [AW-1:0]        bs_addr,
    output logic [NREGS-1:0]     busy
);

    localparam logic [AW-1:0] ZA = AW'(ZR);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == ZR || INIT_IDX == 0) begin
                    regs[i] <= '0;
                end else begin
                    regs[i] <= WIDTH'(init_val(unsigned'(i)));
                end
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i != ZR) begin
                    if (we1 && wa1 == AW'(i)) begin
                        regs[i] <= wd1;
                    end else if (we0 && wa0 == AW'(i)) begin
                        regs[i] <= wd0;
                    end
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .ZR    (ZR)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .bs_en   (bs_en),
        .bs_addr (bs_addr),
        .we0     (we0),
        .wa0     (wa0),
        .we1     (we1),
        .wa1     (wa1),
        .busy    (busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    a;
        logic             hit0;
        logic             hit1;
        logic             bs_hit;
        logic [WIDTH-1:0] dat;
        logic             bsy;

        // Bypass is suppressed under reset so reads show the freshly loaded contents.
        assign a      = ra[k*AW +: AW];
        assign hit1   = (BYPASS != 0) && !reset && we1 && (wa1 == a);
        assign hit0   = (BYPASS != 0) && !reset && we0 && (wa0 == a);
        assign bs_hit = bs_en && (bs_addr == a);

        always_comb begin
            dat = regs[a];
            bsy = busy[a];
            if (a == ZA) begin
                dat = '0;
                bsy = 1'b0;
            end else if (hit1) begin
                dat = wd1;
                bsy = bs_hit;
            end else if (hit0) begin
                dat = wd0;
                bsy = bs_hit;
            end
        end

        assign rd[k*WIDTH +: WIDTH] = dat;
        assign rd_busy[k]           = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: three instances (bypass, no bypass, four read ports) share the write/scoreboard stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, bs_en;
    logic [4:0]  wa0, wa1, bs_addr;
    logic [63:0] wd0, wd1;
    logic [9:0]  ra2;
    logic [19:0] ra4;

    logic [127:0] rd_a, rd_b;
    logic [255:0] rd_c;
    logic [1:0]   rdb_a, rdb_b;
    logic [3:0]   rdb_c;
    logic [31:0]  busy_a, busy_b, busy_c;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .ra(ra2), .rd(rd_a), .rd_busy(rdb_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .bs_en(bs_en), .bs_addr(bs_addr), .busy(busy_a)
    );

    regfile_mp #(.NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .ra(ra2), .rd(rd_b), .rd_busy(rdb_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .bs_en(bs_en), .bs_addr(bs_addr), .busy(busy_b)
    );

    regfile_mp #(.NRD(4), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .ra(ra4), .rd(rd_c), .rd_busy(rdb_c),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .bs_en(bs_en), .bs_addr(bs_addr), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; bs_en = 1'b0;
        wa0 = '0; wa1 = '0; bs_addr = '0;
        wd0 = '0; wd1 = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        ra2 = {5'd31, 5'd5};
        ra4 = {5'd31, 5'd3, 5'd2, 5'd1};
        #1;
        chk("rst_rd0", rd_a[63:0], 64'd5);
        chk("rst_rd1_zr", rd_a[127:64], 64'd0);
        chk("rst_rdbusy", {62'd0, rdb_a}, 64'd0);
        chk("rst_c0", rd_c[63:0], 64'd1);
        chk("rst_c1", rd_c[127:64], 64'd2);
        chk("rst_c2", rd_c[191:128], 64'd3);
        chk("rst_c3", rd_c[255:192], 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_rd0", rd_a[63:0], 64'd5);

        // four-port read with a bypassed write to register 2
        we0 = 1'b1; wa0 = 5'd2; wd0 = 64'h22;
        #1;
        chk("nrd4_p0", rd_c[63:0], 64'd1);
        chk("nrd4_p1_byp", rd_c[127:64], 64'h22);
        chk("nrd4_p2", rd_c[191:128], 64'd3);
        chk("nrd4_p3_zr", rd_c[255:192], 64'd0);
        tick();
        idle();

        // both write ports to register 7
        ra2 = {5'd31, 5'd7};
        we0 = 1'b1; wa0 = 5'd7; wd0 = 64'hAA;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 64'hBB;
        #1;
        chk("dual_byp", rd_a[63:0], 64'hBB);
        chk("dual_nobyp", rd_b[63:0], 64'd7);
        tick();
        idle();
        #1;
        chk("dual_next_a", rd_a[63:0], 64'hBB);
        chk("dual_next_b", rd_b[63:0], 64'hBB);

        // writes to the zero register
        ra2 = {5'd7, 5'd31};
        we0 = 1'b1; wa0 = 5'd31; wd0 = 64'hFFFF;
        we1 = 1'b1; wa1 = 5'd31; wd1 = 64'hFFFF;
        #1;
        chk("zr_same_a", rd_a[63:0], 64'd0);
        chk("zr_same_b", rd_b[63:0], 64'd0);
        tick();
        idle();
        #1;
        chk("zr_after", rd_a[63:0], 64'd0);

        // scoreboard set then clear by writeback
        ra2 = {5'd31, 5'd3};
        bs_en = 1'b1; bs_addr = 5'd3;
        #1;
        chk("sb_pre", {63'd0, rdb_a[0]}, 64'd0);
        tick();
        idle();
        #1;
        chk("sb_busy3", {32'd0, busy_a}, 64'h8);
        chk("sb_rdbusy", {63'd0, rdb_a[0]}, 64'd1);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 64'h33;
        #1;
        chk("sb_clr_byp", {63'd0, rdb_a[0]}, 64'd0);
        chk("sb_clr_nobyp", {63'd0, rdb_b[0]}, 64'd1);
        chk("sb_clr_data", rd_a[63:0], 64'h33);
        tick();
        idle();
        #1;
        chk("sb_cleared_a", {32'd0, busy_a}, 64'd0);
        chk("sb_cleared_b", {32'd0, busy_b}, 64'd0);
        chk("sb_wr_data", rd_b[63:0], 64'h33);

        // set and clear together: new producer wins
        ra2 = {5'd31, 5'd4};
        bs_en = 1'b1; bs_addr = 5'd4;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 64'h44;
        #1;
        chk("setclr_byp_data", rd_a[63:0], 64'h44);
        chk("setclr_byp_busy", {63'd0, rdb_a[0]}, 64'd1);
        tick();
        idle();
        #1;
        chk("setclr_busy4", {32'd0, busy_a}, 64'h10);
        chk("setclr_data_a", rd_a[63:0], 64'h44);
        chk("setclr_data_b", rd_b[63:0], 64'h44);
        bs_en = 1'b1; bs_addr = 5'd31;
        tick();
        idle();
        #1;
        chk("bs_zr_ignored", {32'd0, busy_a}, 64'h10);
        chk("bs_zr_rdbusy", {63'd0, rdb_a[1]}, 64'd0);

        // mid-run reset with an in-flight write
        ra2 = {5'd5, 5'd7};
        we0 = 1'b1; wa0 = 5'd5; wd0 = 64'h55;
        reset = 1'b1;
        #1;
        chk("mid_rst_r7", rd_a[63:0], 64'd7);
        chk("mid_rst_r5", rd_a[127:64], 64'd5);
        chk("mid_rst_busy", {32'd0, busy_a}, 64'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("mid_rst_lost_a", rd_a[127:64], 64'd5);
        chk("mid_rst_lost_b", rd_b[127:64], 64'd5);
        chk("mid_rst_r4", rd_c[63:0], 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the single-write/dual-read datapath register file. Adds a configurable read-port count, two write ports with defined priority, an optional write-to-read bypass and a per-register busy scoreboard. Sits in the decode stage of the pipelined core: read ports feed operand fetch, write ports come from writeback, and busy bits drive the hazard unit.

Parameters:
WIDTH, 64, data width in bits
NREGS, 32, number of architectural registers (power of 2)
AW, $clog2(NREGS), address width (derived, not overridable)
NRD, 2, number of read ports (1..4)
ZR, 31, index of the hard-wired zero register
INIT_IDX, 1, reset contents: 1 = regs[i] holds i, 0 = all zero
BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
ra  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd  out  NRD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH]
rd_busy  out  NRD  busy bit of the register addressed by each read port
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  WIDTH  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  AW  write address, port 1
wd1  in  WIDTH  write data, port 1
bs_en  in  1  scoreboard set: mark bs_addr busy (instruction issued)
bs_addr  in  AW  register to mark busy
busy  out  NREGS  full busy vector

Behaviour:
- Reset (async, active-high): regs[i] = INIT_IDX ? i : 0 for all i; regs[ZR] = 0; busy = 0.
- While reset is asserted, rd reflects the reset contents and rd_busy = 0.
- Reads are combinational, with zero-cycle latency.
- Read of ZR always returns 0 and rd_busy = 0, regardless of writes or bypass.
- Writes are registered on the rising edge of clk.
  - weN=1 with waN≠ZR: regs[waN] <= wdN.
  - Writes to ZR are dropped.
- Both write ports to the same address in the same cycle: port 1 wins; port 0's data is discarded.
- BYPASS=1, read address matching an enabled same-cycle write (≠ZR):
  - rd returns the write data combinationally, with port 1 taking priority.
  - rd_busy for that port returns 0, unless bs_en targets the same register in that cycle.
- BYPASS=0: rd returns the pre-edge contents; the new value is visible one cycle after the write.
- Scoreboard, evaluated per register r each edge:
  - set = bs_en and bs_addr==r.
  - clear = (we0 and wa0==r) or (we1 and wa1==r).
  - set and clear together → busy[r] = 1 (new producer wins).
  - clear only → 0; set only → 1; neither → hold.
  - busy[ZR] is permanently 0; bs_en to ZR is ignored.
- A write to a non-busy register is legal: data is updated and busy stays 0.
- rd_busy[k] = busy[ra_k], modified by the bypass rule above.
- Reset asserted mid-operation: immediate async clear of busy and reload of the init contents; in-flight writes that cycle are lost.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Package rf_pkg holds: WIDTH_DEF, NREGS_DEF, ZR_DEF constants; the reg_addr_t and reg_data_t typedefs; the init-value function init_val(i).
- Sub-module rf_scoreboard holds the busy vector and the set/clear priority logic. It takes bs_en/bs_addr and both write enables/addresses, and outputs busy.
- Storage, write arbitration and bypass muxes stay in regfile_mp.

Test Plan:
1. Reset with INIT_IDX=1, then read ra={5,31} → rd={5,0}, rd_busy=0; reassert reset mid-run after writes → contents return to the index values.
2. Simultaneous writes: we0 wa0=7 wd0=0xAA and we1 wa1=7 wd1=0xBB. Same-cycle read of 7 → 0xBB with BYPASS=1, old value 7 with BYPASS=0; next cycle read → 0xBB.
3. Write wd=0xFFFF to ZR on both ports → read of 31 returns 0 that cycle and after.
4. Scoreboard: bs_en bs_addr=3 → busy[3]=1 next cycle, rd_busy=1 when reading 3. Then we0 wa0=3 → busy[3]=0 after the edge; with BYPASS=1, rd_busy=0 combinationally during the write cycle.
5. Same cycle bs_en bs_addr=4 and we1 wa1=4 → busy[4]=1 after the edge and regs[4] updated; bs_en bs_addr=31 → busy[31] stays 0.
6. NRD=4 configuration with four distinct addresses {1,2,3,ZR} and one bypassed write to 2 → rd={1,wd,3,0}.
